// File: rtl/jump_issue_if.sv
// Handshake and operand bundle between the jump issue controller, dispatch, the jump FU and fetch/writeback.
// The master modport is the controller's view; the slave modport is its environment.
interface jump_issue_if;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_jal;
    logic        issue_jalr;
    logic        issue_branch;
    logic [2:0]  issue_cmp_ctrl;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic [31:0] issue_imm;
    logic [31:0] issue_pc;
    logic [4:0]  issue_rd;
    logic        flush;
    logic        fu_en;
    logic        fu_jalr;
    logic [2:0]  fu_cmp_ctrl;
    logic [31:0] fu_rs1;
    logic [31:0] fu_rs2;
    logic [31:0] fu_imm;
    logic [31:0] fu_pc;
    logic        fu_finish;
    logic        fu_cmp_res;
    logic [31:0] fu_pc_jump;
    logic [31:0] fu_pc_wb;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        timeout_err;

    modport master (
        input  issue_valid, issue_jal, issue_jalr, issue_branch, issue_cmp_ctrl,
               issue_rs1, issue_rs2, issue_imm, issue_pc, issue_rd, flush,
               fu_finish, fu_cmp_res, fu_pc_jump, fu_pc_wb, wb_ready,
        output issue_ready, fu_en, fu_jalr, fu_cmp_ctrl, fu_rs1, fu_rs2, fu_imm, fu_pc,
               redirect_valid, redirect_pc, wb_valid, wb_rd, wb_data, timeout_err
    );

    modport slave (
        output issue_valid, issue_jal, issue_jalr, issue_branch, issue_cmp_ctrl,
               issue_rs1, issue_rs2, issue_imm, issue_pc, issue_rd, flush,
               fu_finish, fu_cmp_res, fu_pc_jump, fu_pc_wb, wb_ready,
        input  issue_ready, fu_en, fu_jalr, fu_cmp_ctrl, fu_rs1, fu_rs2, fu_imm, fu_pc,
               redirect_valid, redirect_pc, wb_valid, wb_rd, wb_data, timeout_err
    );
endinterface

// File: rtl/jump_issue_ctrl.sv
// Jump FU initiator: issues one jump/branch, holds operands, turns the FU result into a PC redirect and link writeback.
// Optional JUMP_STATS_EN adds wrapping branch / taken-branch counters.
module jump_issue_ctrl #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef JUMP_STATS_EN
    output logic [31:0] stat_branch_cnt,
    output logic [31:0] stat_taken_cnt,
`endif
    jump_issue_if.master bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              op_jal;
    logic              op_branch;
    logic [RD_W-1:0]   op_rd;

    logic              issue_ready_q;
    logic              fu_en_q;
    logic              fu_jalr_q;
    logic [2:0]        fu_cmp_ctrl_q;
    logic [XLEN-1:0]   fu_rs1_q;
    logic [XLEN-1:0]   fu_rs2_q;
    logic [XLEN-1:0]   fu_imm_q;
    logic [XLEN-1:0]   fu_pc_q;
    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic              wb_valid_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              timeout_err_q;

    logic              handshake;
    logic              taken;
    logic              wb_need;
    logic              timeout_hit;
    logic [XLEN-1:0]   target;

    // A flush in IDLE blocks the handshake so a killed instruction is never started.
    assign handshake   = (state == S_IDLE) & issue_ready_q & bus.issue_valid & ~bus.flush;
    assign taken       = op_jal | fu_jalr_q | (op_branch & bus.fu_cmp_res);
    assign wb_need     = (op_jal | fu_jalr_q) & (op_rd != '0);
    assign timeout_hit = (cnt == CNT_LAST);
    assign target      = fu_jalr_q ? {bus.fu_pc_jump[XLEN-1:1], 1'b0} : bus.fu_pc_jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            op_jal           <= 1'b0;
            op_branch        <= 1'b0;
            op_rd            <= '0;
            issue_ready_q    <= 1'b0;
            fu_en_q          <= 1'b0;
            fu_jalr_q        <= 1'b0;
            fu_cmp_ctrl_q    <= '0;
            fu_rs1_q         <= '0;
            fu_rs2_q         <= '0;
            fu_imm_q         <= '0;
            fu_pc_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            timeout_err_q    <= 1'b0;
        end else begin
            fu_en_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            timeout_err_q    <= 1'b0;
            issue_ready_q    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        op_jal        <= bus.issue_jal;
                        op_branch     <= bus.issue_branch;
                        op_rd         <= bus.issue_rd;
                        fu_jalr_q     <= bus.issue_jalr;
                        fu_cmp_ctrl_q <= bus.issue_cmp_ctrl;
                        fu_rs1_q      <= bus.issue_rs1;
                        fu_rs2_q      <= bus.issue_rs2;
                        fu_imm_q      <= bus.issue_imm;
                        fu_pc_q       <= bus.issue_pc;
                        fu_en_q       <= 1'b1;
                        state         <= S_ISSUE;
                    end else begin
                        issue_ready_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= bus.flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (bus.fu_finish) begin
                        // A flush coinciding with finish discards the result outright.
                        if (bus.flush) begin
                            state         <= S_IDLE;
                            issue_ready_q <= 1'b1;
                        end else begin
                            redirect_valid_q <= taken;
                            redirect_pc_q    <= target;
                            wb_valid_q       <= wb_need;
                            wb_rd_q          <= op_rd;
                            wb_data_q        <= bus.fu_pc_wb;
                            state            <= S_RESP;
                        end
                    end else if (timeout_hit) begin
                        timeout_err_q <= 1'b1;
                        issue_ready_q <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (bus.flush) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.fu_finish) begin
                        issue_ready_q <= 1'b1;
                        state         <= S_IDLE;
                    end else if (timeout_hit) begin
                        timeout_err_q <= 1'b1;
                        issue_ready_q <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.flush || !wb_valid_q || bus.wb_ready) begin
                        wb_valid_q    <= 1'b0;
                        issue_ready_q <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    issue_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef JUMP_STATS_EN
    // Counted only on a real WAIT->RESP completion; flushed or timed-out ops never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branch_cnt <= '0;
            stat_taken_cnt  <= '0;
        end else if ((state == S_WAIT) && bus.fu_finish && !bus.flush && op_branch) begin
            stat_branch_cnt <= stat_branch_cnt + 32'd1;
            if (bus.fu_cmp_res) stat_taken_cnt <= stat_taken_cnt + 32'd1;
        end
    end
`endif

    assign bus.issue_ready    = issue_ready_q;
    assign bus.fu_en          = fu_en_q;
    assign bus.fu_jalr        = fu_jalr_q;
    assign bus.fu_cmp_ctrl    = fu_cmp_ctrl_q;
    assign bus.fu_rs1         = fu_rs1_q;
    assign bus.fu_rs2         = fu_rs2_q;
    assign bus.fu_imm         = fu_imm_q;
    assign bus.fu_pc          = fu_pc_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_rd          = wb_rd_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_jump_issue_ctrl.sv
// Bench for jump_issue_ctrl: directed ops, a simple jump-FU model, and a transaction-level reference model.
module tb_jump_issue_ctrl;

    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jump_issue_if bus ();

`ifdef JUMP_STATS_EN
    logic [31:0] stat_branch_cnt;
    logic [31:0] stat_taken_cnt;
`endif

    jump_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef JUMP_STATS_EN
        .stat_branch_cnt (stat_branch_cnt),
        .stat_taken_cnt  (stat_taken_cnt),
`endif
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cmp_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Jump FU: combinational results on the held operands, finish after fin_delay cycles (0 = never).
    int fin_delay = 1;
    assign bus.fu_pc_jump = bus.fu_jalr ? bus.fu_rs1 + bus.fu_imm : bus.fu_pc + bus.fu_imm;
    assign bus.fu_pc_wb   = bus.fu_pc + 32'd4;
    assign bus.fu_cmp_res = cmp_fn(bus.fu_cmp_ctrl, bus.fu_rs1, bus.fu_rs2);

    initial begin
        int cd;
        cd = 0;
        bus.fu_finish = 1'b0;
        forever begin
            @(negedge clk);
            bus.fu_finish = 1'b0;
            if (!rst_n) cd = 0;
            else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) bus.fu_finish = 1'b1;
                end
                if (bus.fu_en) cd = fin_delay;
            end
        end
    end

    // Reference model: tracks one op from acceptance to completion.
    logic        e_issue_ready, e_fu_en, e_fu_jalr, e_redirect_valid, e_wb_valid, e_timeout;
    logic [2:0]  e_fu_cmp;
    logic [31:0] e_fu_rs1, e_fu_rs2, e_fu_imm, e_fu_pc, e_redirect_pc, e_wb_data;
    logic [4:0]  e_wb_rd;
    logic        m_busy, m_in_issue, m_killed, m_resp, m_jal, m_br;
    logic [4:0]  m_rd;
    int          m_waited;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                e_issue_ready = 0; e_fu_en = 0; e_fu_jalr = 0; e_redirect_valid = 0;
                e_wb_valid = 0; e_timeout = 0; e_fu_cmp = 0; e_fu_rs1 = 0; e_fu_rs2 = 0;
                e_fu_imm = 0; e_fu_pc = 0; e_redirect_pc = 0; e_wb_data = 0; e_wb_rd = 0;
                m_busy = 0; m_in_issue = 0; m_killed = 0; m_resp = 0; m_jal = 0; m_br = 0;
                m_rd = 0; m_waited = 0;
            end else begin
                e_fu_en = 0; e_redirect_valid = 0; e_timeout = 0;
                if (!m_busy) begin
                    if (e_issue_ready && bus.issue_valid && !bus.flush) begin
                        e_fu_jalr = bus.issue_jalr; e_fu_cmp = bus.issue_cmp_ctrl;
                        e_fu_rs1 = bus.issue_rs1; e_fu_rs2 = bus.issue_rs2;
                        e_fu_imm = bus.issue_imm; e_fu_pc = bus.issue_pc;
                        m_jal = bus.issue_jal; m_br = bus.issue_branch; m_rd = bus.issue_rd;
                        m_busy = 1; m_in_issue = 1; m_killed = 0; m_resp = 0;
                        e_fu_en = 1; e_issue_ready = 0;
                    end else e_issue_ready = 1;
                end else if (m_resp) begin
                    if (bus.flush || !e_wb_valid || bus.wb_ready) begin
                        e_wb_valid = 0; m_busy = 0; m_resp = 0; e_issue_ready = 1;
                    end
                end else if (m_in_issue) begin
                    m_in_issue = 0; m_waited = 0;
                    if (bus.flush) m_killed = 1;
                end else if (bus.fu_finish) begin
                    if (m_killed || bus.flush) begin
                        m_busy = 0; e_issue_ready = 1;
                    end else begin
                        logic [31:0] tgt;
                        tgt = e_fu_jalr ? e_fu_rs1 + e_fu_imm : e_fu_pc + e_fu_imm;
                        if (e_fu_jalr) tgt[0] = 1'b0;
                        e_redirect_valid = m_jal | e_fu_jalr | (m_br & cmp_fn(e_fu_cmp, e_fu_rs1, e_fu_rs2));
                        e_redirect_pc = tgt;
                        e_wb_valid = (m_jal | e_fu_jalr) && (m_rd != 0);
                        e_wb_rd = m_rd;
                        e_wb_data = e_fu_pc + 32'd4;
                        m_resp = 1;
                    end
                end else if (m_waited == int'(TIMEOUT) - 1) begin
                    e_timeout = 1; m_busy = 0; e_issue_ready = 1;
                end else begin
                    m_waited++;
                    if (bus.flush) m_killed = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check32("issue_ready", 32'(bus.issue_ready), 32'(e_issue_ready));
                check32("fu_en", 32'(bus.fu_en), 32'(e_fu_en));
                check32("fu_jalr", 32'(bus.fu_jalr), 32'(e_fu_jalr));
                check32("fu_cmp_ctrl", 32'(bus.fu_cmp_ctrl), 32'(e_fu_cmp));
                check32("fu_rs1", bus.fu_rs1, e_fu_rs1);
                check32("fu_rs2", bus.fu_rs2, e_fu_rs2);
                check32("fu_imm", bus.fu_imm, e_fu_imm);
                check32("fu_pc", bus.fu_pc, e_fu_pc);
                check32("redirect_valid", 32'(bus.redirect_valid), 32'(e_redirect_valid));
                if (e_redirect_valid) check32("redirect_pc", bus.redirect_pc, e_redirect_pc);
                check32("wb_valid", 32'(bus.wb_valid), 32'(e_wb_valid));
                if (e_wb_valid) begin
                    check32("wb_rd", 32'(bus.wb_rd), 32'(e_wb_rd));
                    check32("wb_data", bus.wb_data, e_wb_data);
                end
                check32("timeout_err", 32'(bus.timeout_err), 32'(e_timeout));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (bus.issue_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check32("ready_before_issue", 32'(bus.issue_ready), 32'd1);
    endtask

    // Offer one op; returns at the negedge of cycle T+1 (fu_en cycle).
    task automatic do_op(input logic jal, input logic jalr, input logic br, input logic [2:0] cmp,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rd);
        wait_ready();
        bus.issue_jal = jal; bus.issue_jalr = jalr; bus.issue_branch = br;
        bus.issue_cmp_ctrl = cmp; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
        bus.issue_imm = imm; bus.issue_pc = pc; bus.issue_rd = rd;
        bus.issue_valid = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    initial begin
        int k;
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.issue_valid = 0; bus.issue_jal = 0; bus.issue_jalr = 0; bus.issue_branch = 0;
        bus.issue_cmp_ctrl = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_imm = 0;
        bus.issue_pc = 0; bus.issue_rd = 0; bus.flush = 0; bus.wb_ready = 1;

        step(3);
        check32("reset_issue_ready", 32'(bus.issue_ready), 32'd0);
        check32("reset_fu_pc", bus.fu_pc, 32'd0);
        rst_n = 1'b1;
        step(2);

        // BEQ taken
        fin_delay = 1;
        do_op(0, 0, 1, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 5'd7);
        check32("beq_fu_en_t1", 32'(bus.fu_en), 32'd1);
        step(2);
        check32("beq_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check32("beq_redirect_pc", bus.redirect_pc, 32'h120);
        check32("beq_wb_valid", 32'(bus.wb_valid), 32'd0);
        step(1);
        check32("beq_redirect_once", 32'(bus.redirect_valid), 32'd0);

        // BNE with equal operands: not taken
        do_op(0, 0, 1, 3'd1, 32'd9, 32'd9, 32'h40, 32'h180, 5'd0);
        step(2);
        check32("bne_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        step(1);
        check32("bne_ready_t4", 32'(bus.issue_ready), 32'd1);

        // JALR with writeback stall
        bus.wb_ready = 0;
        do_op(0, 1, 0, 3'd0, 32'h2003, 32'd0, 32'd4, 32'h40, 5'd1);
        step(2);
        check32("jalr_redirect_pc", bus.redirect_pc, 32'h2006);
        check32("jalr_wb_data", bus.wb_data, 32'h44);
        check32("jalr_fu_rs1", bus.fu_rs1, 32'h2003);
        step(2);
        check32("jalr_wb_held", 32'(bus.wb_valid), 32'd1);
        step(1);
        bus.wb_ready = 1;
        step(1);
        check32("jalr_wb_done", 32'(bus.wb_valid), 32'd0);

        // JAL to x0: redirect only
        do_op(1, 0, 0, 3'd0, 32'd0, 32'd0, 32'h40, 32'h200, 5'd0);
        step(2);
        check32("jal_x0_redirect_pc", bus.redirect_pc, 32'h240);
        check32("jal_x0_wb_valid", 32'(bus.wb_valid), 32'd0);

        // Flush during WAIT, FU finishes late
        fin_delay = 3;
        do_op(1, 0, 0, 3'd0, 32'd0, 32'd0, 32'h10, 32'h280, 5'd3);
        step(1);
        bus.flush = 1;
        step(1);
        bus.flush = 0;
        step(2);
        check32("drain_ready", 32'(bus.issue_ready), 32'd1);
        fin_delay = 1;
        do_op(0, 0, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h300, 5'd0);
        step(2);
        check32("blt_redirect_pc", bus.redirect_pc, 32'h2F8);

        // Flush in the ISSUE cycle
        do_op(1, 0, 0, 3'd0, 32'd0, 32'd0, 32'h10, 32'h500, 5'd5);
        bus.flush = 1;
        step(1);
        bus.flush = 0;
        step(1);
        check32("flush_issue_no_wb", 32'(bus.wb_valid), 32'd0);

        // Flush in RESP drops a stalled writeback
        bus.wb_ready = 0;
        do_op(1, 0, 0, 3'd0, 32'd0, 32'd0, 32'h8, 32'h600, 5'd4);
        step(2);
        bus.flush = 1;
        step(1);
        bus.flush = 0;
        check32("flush_resp_wb", 32'(bus.wb_valid), 32'd0);
        bus.wb_ready = 1;

        // Flush in IDLE blocks the handshake
        wait_ready();
        bus.issue_valid = 1; bus.flush = 1;
        step(1);
        bus.issue_valid = 0; bus.flush = 0;
        check32("flush_idle_fu_en", 32'(bus.fu_en), 32'd0);

        // FU never finishes: timeout
        fin_delay = 0;
        do_op(1, 0, 0, 3'd0, 32'd0, 32'd0, 32'h4, 32'h700, 5'd2);
        k = 0;
        while (bus.timeout_err !== 1'b1 && k < 30) begin
            step(1);
            k++;
        end
        check32("timeout_latency", 32'(k), 32'(TIMEOUT + 1));
        check32("timeout_ready", 32'(bus.issue_ready), 32'd1);

        // Async reset in the middle of RESP
        fin_delay = 1;
        bus.wb_ready = 0;
        do_op(0, 1, 0, 3'd0, 32'h3000, 32'd0, 32'd8, 32'h80, 5'd2);
        step(2);
        check32("pre_reset_wb_valid", 32'(bus.wb_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check32("async_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check32("async_rst_redirect", 32'(bus.redirect_valid), 32'd0);
        check32("async_rst_fu_rs1", bus.fu_rs1, 32'd0);
        check32("async_rst_wb_data", bus.wb_data, 32'd0);
        step(2);
        bus.wb_ready = 1;
        rst_n = 1'b1;
        step(1);

        // Recovery op after reset
        do_op(0, 0, 1, 3'd6, 32'd1, 32'd2, 32'h100, 32'h900, 5'd0);
        step(2);
        check32("recover_redirect_pc", bus.redirect_pc, 32'hA00);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jump_issue_ctrl.md
Name: jump_issue_ctrl

Overview:
- Initiator side of the jump functional unit: accepts one jump/branch from dispatch, pulses the FU enable, and holds operands stable until the FU signals finish.
- Consumes the FU outputs: cmp result, jump target and return address.
- Produces a one-cycle PC redirect to fetch and a link-register writeback request with valid/ready handshake.
- Sits between the issue stage and the jump FU on one side, and the fetch/writeback arbiter on the other.

Parameters:
- TIMEOUT, 8, max cycles in WAIT/DRAIN without fu_finish before abort; counter is 4 bits, legal range 2..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  dispatch offers an instruction
- issue_ready  out  1  controller idle; handshake when both are 1
- issue_jal, issue_jalr, issue_branch  in  1 each  one-hot op class
- issue_cmp_ctrl  in  3  branch compare code
- issue_rs1, issue_rs2, issue_imm, issue_pc  in  32 each  operands
- issue_rd  in  5  link destination
- flush  in  1  kill in-flight op
- fu_en  out  1  one-cycle FU start pulse
- fu_jalr  out  1  held operand
- fu_cmp_ctrl  out  3  held operand
- fu_rs1, fu_rs2, fu_imm, fu_pc  out  32 each  held operands
- fu_finish  in  1  FU result valid
- fu_cmp_res  in  1  FU result
- fu_pc_jump, fu_pc_wb  in  32 each  FU results
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  new fetch PC
- wb_valid  out  1  writeback request
- wb_rd  out  5  writeback destination
- wb_data  out  32  link value
- wb_ready  in  1  writeback accepted
- timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including fu_* operands and timeout counter.
- States and transitions:
  - IDLE: issue_ready=1. On issue_valid, capture all issue_* fields into operand registers, then go to ISSUE.
  - ISSUE: fu_en=1 for this cycle only. Next state WAIT; counter cleared.
  - WAIT: counter increments each cycle. On fu_finish:
    - latch cmp_res, pc_jump, pc_wb;
    - taken = jal | jalr | (branch & cmp_res);
    - go to RESP.
    If counter reaches TIMEOUT-1 without finish: timeout_err pulse, go to IDLE.
  - RESP:
    - First cycle: redirect_valid=1 if taken.
    - redirect_pc = pc_jump with bit0 cleared when jalr, otherwise pc_jump unmodified.
    - wb_valid=1 when (jal|jalr) & rd!=0; held with stable wb_rd/wb_data=pc_wb until wb_ready, then IDLE.
    - If no writeback is needed, return to IDLE after the single RESP cycle.
    - redirect_valid never exceeds one cycle, even while wb stalls.
  - DRAIN: entered on flush during ISSUE or WAIT. Holds operands and waits for fu_finish, or TIMEOUT, to discard the stale FU result. Then IDLE, with no redirect and no wb.
- fu_* operand outputs remain stable from ISSUE through the fu_finish cycle; FU target/return paths are combinational on live operands.
- Flush rules:
  - Flush in IDLE: ignored, and an issue handshake in the same cycle is blocked.
  - Flush in RESP: drop wb_valid next cycle, go to IDLE; a redirect already pulsed stands.
  - Flush in the ISSUE cycle: fu_en still pulses, then DRAIN.
- fu_finish outside WAIT/DRAIN is ignored.
- Latency: handshake cycle T, fu_en at T+1, finish at T+2, redirect/wb_valid at T+3. Minimum 4 cycles per op, no overlap.
- Reset mid-operation returns to IDLE immediately; the FU is reset by the same rst_n.

Optional Feature:
- JUMP_STATS_EN defined: adds outputs stat_branch_cnt[31:0] and stat_taken_cnt[31:0], both wrapping.
  - stat_branch_cnt increments on each WAIT→RESP transition with branch=1.
  - stat_taken_cnt increments when branch & cmp_res on that transition.
  - Flushed and timed-out ops are not counted. Counters reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, FU model finishes 1 cycle after fu_en: redirect_valid pulse at T+3, redirect_pc=0x120, wb_valid stays 0.
- BNE with equal operands: cmp_res=0, no redirect, no wb, issue_ready=1 at T+4.
- JALR, rs1=0x2003, imm=4, rd=1, pc=0x40, wb_ready held low 3 cycles:
  - redirect_pc=0x2006 for one cycle;
  - wb_valid held 4 cycles with wb_data=0x44;
  - fu_rs1 stable throughout.
- JAL with rd=0: redirect only, no wb_valid.
- Flush asserted in the WAIT cycle: DRAIN until fu_finish, no redirect/wb, and the next issue is accepted afterwards with correct results.
- FU model never finishes: timeout_err pulses after TIMEOUT cycles, state returns to IDLE. Apply rst_n=0 mid-RESP: all outputs 0 asynchronously.
